// File: rtl/os_sa_sequencer.sv
// Sequences one output-stationary C = A x B job on the systolic array: clear, skewed feed, drain, done.
// Skew adds i+1 cycles on lane i; the array and skew stall together whenever no beat is accepted during FEED.
module os_sa_sequencer #(
    parameter int WIDTH_A = 16,
    parameter int WIDTH_B = 16,
    parameter int X_AXIS  = 3,
    parameter int Y_AXIS  = 3,
    parameter int K_MAX   = 64,
    parameter int PE_LAT  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [$clog2(K_MAX+1)-1:0]  k_len,
    input  logic                        abort,
    input  logic                        vec_valid,
    output logic                        vec_ready,
    input  logic [WIDTH_A*Y_AXIS-1:0]   a_vec,
    input  logic [WIDTH_B*X_AXIS-1:0]   b_vec,
    output logic [WIDTH_A*Y_AXIS-1:0]   act_out,
    output logic [WIDTH_B*X_AXIS-1:0]   wei_out,
    output logic                        reg_clear,
    output logic                        pipeline_en,
    output logic                        busy,
    output logic                        done
);

    localparam int KW        = $clog2(K_MAX+1);
    localparam int DRAIN_LEN = X_AXIS + Y_AXIS - 1 + PE_LAT;
    localparam int DW        = $clog2(DRAIN_LEN+1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [KW-1:0]  r_k_len;
    logic [KW-1:0]  r_beat_cnt;
    logic [DW-1:0]  r_drain_cnt;
    logic           r_reg_clear;
    logic           r_pe_fixed;
    logic           r_vec_ready;
    logic           r_busy;
    logic           r_done;

    logic           w_beat;
    logic           w_shift;
    logic           w_flush;
    logic [KW-1:0]  w_k_sat;

    assign w_k_sat = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
    assign w_beat  = vec_valid & r_vec_ready;
    // CLEAR and DRAIN always advance; FEED advances only on an accepted beat.
    assign w_shift = r_pe_fixed | w_beat;
    assign w_flush = abort & (r_state != S_IDLE);

    assign vec_ready   = r_vec_ready;
    assign reg_clear   = r_reg_clear;
    assign pipeline_en = w_shift;
    assign busy        = r_busy;
    assign done        = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_k_len     <= '0;
            r_beat_cnt  <= '0;
            r_drain_cnt <= '0;
            r_reg_clear <= 1'b0;
            r_pe_fixed  <= 1'b0;
            r_vec_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (w_flush) begin
            r_state     <= S_IDLE;
            r_reg_clear <= 1'b0;
            r_pe_fixed  <= 1'b0;
            r_vec_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_state     <= S_CLEAR;
                        r_k_len     <= w_k_sat;
                        r_reg_clear <= 1'b1;
                        r_pe_fixed  <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_reg_clear <= 1'b0;
                    r_pe_fixed  <= 1'b0;
                    r_beat_cnt  <= '0;
                    r_drain_cnt <= '0;
                    if (r_k_len == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state     <= S_FEED;
                        r_vec_ready <= 1'b1;
                    end
                end
                S_FEED: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + KW'(1);
                        if (r_beat_cnt == r_k_len - KW'(1)) begin
                            r_state     <= S_DRAIN;
                            r_vec_ready <= 1'b0;
                            r_pe_fixed  <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    r_drain_cnt <= r_drain_cnt + DW'(1);
                    if (r_drain_cnt == DW'(DRAIN_LEN-1)) begin
                        r_state    <= S_DONE;
                        r_pe_fixed <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Zeros enter the skew outside accepted beats, so CLEAR and DRAIN push only zeros.
    for (genvar i = 0; i < Y_AXIS; i++) begin : g_act
        logic [WIDTH_A-1:0] r_sr [0:i];
        always_ff @(posedge clk or posedge rst) begin
            if (rst || w_flush) begin
                for (int s = 0; s <= i; s++) r_sr[s] <= '0;
            end else if (w_shift) begin
                r_sr[0] <= w_beat ? a_vec[i*WIDTH_A +: WIDTH_A] : '0;
                for (int s = 1; s <= i; s++) r_sr[s] <= r_sr[s-1];
            end
        end
        assign act_out[i*WIDTH_A +: WIDTH_A] = r_sr[i];
    end

    for (genvar j = 0; j < X_AXIS; j++) begin : g_wei
        logic [WIDTH_B-1:0] r_sr [0:j];
        always_ff @(posedge clk or posedge rst) begin
            if (rst || w_flush) begin
                for (int s = 0; s <= j; s++) r_sr[s] <= '0;
            end else if (w_shift) begin
                r_sr[0] <= w_beat ? b_vec[j*WIDTH_B +: WIDTH_B] : '0;
                for (int s = 1; s <= j; s++) r_sr[s] <= r_sr[s-1];
            end
        end
        assign wei_out[j*WIDTH_B +: WIDTH_B] = r_sr[j];
    end

endmodule

// File: tb/tb_os_sa_sequencer.sv
// Directed bench for os_sa_sequencer driving a behavioural 3x3 output-stationary array model.
module tb_os_sa_sequencer;

    localparam int WA = 16;
    localparam int WB = 16;
    localparam int N  = 3;

    logic            clk;
    logic            rst;
    logic            start;
    logic [6:0]      k_len;
    logic            abort;
    logic            vec_valid;
    logic            vec_ready;
    logic [WA*N-1:0] a_vec;
    logic [WB*N-1:0] b_vec;
    logic [WA*N-1:0] act_out;
    logic [WB*N-1:0] wei_out;
    logic            reg_clear;
    logic            pipeline_en;
    logic            busy;
    logic            done;

    int checks   = 0;
    int failures = 0;

    logic [WA*N-1:0] hist_act [0:15];
    logic [WB*N-1:0] hist_wei [0:15];

    os_sa_sequencer #(
        .WIDTH_A(WA), .WIDTH_B(WB), .X_AXIS(N), .Y_AXIS(N), .K_MAX(64), .PE_LAT(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .abort(abort),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .a_vec(a_vec), .b_vec(b_vec),
        .act_out(act_out), .wei_out(wei_out), .reg_clear(reg_clear),
        .pipeline_en(pipeline_en), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array model: activations flow along rows, weights down columns; reg_clear empties every PE.
    int m_act [N][N];
    int m_wei [N][N];
    int m_acc [N][N];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    m_act[i][j] <= 0; m_wei[i][j] <= 0; m_acc[i][j] <= 0;
                end
        end else if (pipeline_en) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    if (reg_clear) begin
                        m_act[i][j] <= 0; m_wei[i][j] <= 0; m_acc[i][j] <= 0;
                    end else begin
                        m_acc[i][j] <= m_acc[i][j] + m_act[i][j] * m_wei[i][j];
                        m_act[i][j] <= (j == 0) ? int'(act_out[i*WA +: WA]) : m_act[i][j-1];
                        m_wei[i][j] <= (i == 0) ? int'(wei_out[j*WB +: WB]) : m_wei[i-1][j];
                    end
                end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_mac(input string tag, input int exp [9]);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("%s_C%0d%0d", tag, i, j), 64'(m_acc[i][j]), 64'(exp[i*N+j]));
    endtask

    // One job from the start cycle (c=0); expected control outputs follow the state sequence.
    task automatic run_job(input string tag, input int k, input logic [WA*N-1:0] ab [3],
                           input logic [WB*N-1:0] bb [3], input int stall_c, input int stall_n,
                           input int done_c, input int abort_c);
        int  beat;
        int  last;
        bit  exp_rdy, exp_pe, exp_busy, exp_done, aborted, stalled;
        beat = 0;
        last = (abort_c >= 0) ? abort_c + 1 : done_c + 1;
        for (int c = 0; c <= last; c++) begin
            aborted = (abort_c >= 0) && (c > abort_c);
            stalled = (c >= stall_c) && (c < stall_c + stall_n);
            exp_rdy = !aborted && (k > 0) && (c >= 2) && (beat < k);
            start     = (c == 0);
            k_len     = 7'(k);
            abort     = (c == abort_c);
            vec_valid = (c >= 2) && (beat < k) && !stalled && !aborted;
            a_vec     = (beat < k) ? ab[beat] : '0;
            b_vec     = (beat < k) ? bb[beat] : '0;
            exp_pe    = !aborted && ((c == 1) || (vec_valid && exp_rdy) ||
                        ((k > 0) && (beat >= k) && (c < done_c)));
            exp_busy  = !aborted && (c >= 1) && (c <= done_c);
            exp_done  = !aborted && (c == done_c);
            #1;
            chk($sformatf("%s_c%0d_busy", tag, c), 64'(busy), 64'(exp_busy));
            chk($sformatf("%s_c%0d_done", tag, c), 64'(done), 64'(exp_done));
            chk($sformatf("%s_c%0d_clr", tag, c), 64'(reg_clear), 64'(!aborted && c == 1));
            chk($sformatf("%s_c%0d_rdy", tag, c), 64'(vec_ready), 64'(exp_rdy));
            chk($sformatf("%s_c%0d_pe", tag, c), 64'(pipeline_en), 64'(exp_pe));
            if (aborted) begin
                chk($sformatf("%s_c%0d_act0", tag, c), 64'(act_out), 64'(0));
                chk($sformatf("%s_c%0d_wei0", tag, c), 64'(wei_out), 64'(0));
            end
            if (c < 16) begin
                hist_act[c] = act_out;
                hist_wei[c] = wei_out;
            end
            if (vec_valid && exp_rdy) beat++;
            @(posedge clk);
            #1;
        end
        start = 1'b0; abort = 1'b0; vec_valid = 1'b0;
    endtask

    logic [WA*N-1:0] a_m  [3];
    logic [WB*N-1:0] b_i  [3];
    logic [WB*N-1:0] b_2i [3];
    logic [WA*N-1:0] a_s  [3];
    logic [WB*N-1:0] b_s  [3];
    int exp_a  [9];
    int exp_2a [9];
    int exp_z  [9];
    int exp_s  [9];

    initial begin
        a_m  = '{{16'd7, 16'd4, 16'd1}, {16'd8, 16'd5, 16'd2}, {16'd9, 16'd6, 16'd3}};
        b_i  = '{{16'd0, 16'd0, 16'd1}, {16'd0, 16'd1, 16'd0}, {16'd1, 16'd0, 16'd0}};
        b_2i = '{{16'd0, 16'd0, 16'd2}, {16'd0, 16'd2, 16'd0}, {16'd2, 16'd0, 16'd0}};
        a_s  = '{{16'd7, 16'd4, 16'd1}, 48'd0, 48'd0};
        b_s  = '{{16'd3, 16'd2, 16'd9}, 48'd0, 48'd0};
        exp_a  = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        exp_2a = '{2, 4, 6, 8, 10, 12, 14, 16, 18};
        exp_z  = '{default: 0};
        exp_s  = '{9, 2, 3, 36, 8, 12, 63, 14, 21};

        rst = 1'b1; start = 1'b0; k_len = '0; abort = 1'b0;
        vec_valid = 1'b0; a_vec = '0; b_vec = '0;
        tick(); tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_rdy", 64'(vec_ready), 64'(0));
        chk("rst_pe", 64'(pipeline_en), 64'(0));
        chk("rst_clr", 64'(reg_clear), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_act", 64'(act_out), 64'(0));
        chk("rst_wei", 64'(wei_out), 64'(0));
        rst = 1'b0;
        tick();

        // Continuous feed: beats at cycles 2-4, drain 5-10, done at 11.
        run_job("job1", 3, a_m, b_i, 99, 0, 11, -1);
        chk_mac("job1", exp_a);

        // Two-cycle bubble at cycles 3-4: skew frozen, done slips to 13.
        run_job("stall", 3, a_m, b_i, 3, 2, 13, -1);
        chk("stall_act3", 64'(hist_act[3]), 64'({16'd0, 16'd0, 16'd1}));
        chk("stall_act4", 64'(hist_act[4]), 64'({16'd0, 16'd0, 16'd1}));
        chk("stall_act5", 64'(hist_act[5]), 64'({16'd0, 16'd0, 16'd1}));
        chk("stall_act6", 64'(hist_act[6]), 64'({16'd0, 16'd4, 16'd2}));
        chk("stall_wei4", 64'(hist_wei[4]), 64'({16'd0, 16'd0, 16'd1}));
        chk_mac("stall", exp_a);

        // Single beat accepted at cycle 2 walks diagonally across the lanes.
        run_job("skew", 1, a_s, b_s, 99, 0, 9, -1);
        chk("skew_act2", 64'(hist_act[2]), 64'(0));
        chk("skew_act3", 64'(hist_act[3]), 64'({16'd0, 16'd0, 16'd1}));
        chk("skew_act4", 64'(hist_act[4]), 64'({16'd0, 16'd4, 16'd0}));
        chk("skew_act5", 64'(hist_act[5]), 64'({16'd7, 16'd0, 16'd0}));
        chk("skew_act6", 64'(hist_act[6]), 64'(0));
        chk("skew_wei2", 64'(hist_wei[2]), 64'(0));
        chk("skew_wei3", 64'(hist_wei[3]), 64'({16'd0, 16'd0, 16'd9}));
        chk("skew_wei4", 64'(hist_wei[4]), 64'({16'd0, 16'd2, 16'd0}));
        chk("skew_wei5", 64'(hist_wei[5]), 64'({16'd3, 16'd0, 16'd0}));
        chk("skew_wei6", 64'(hist_wei[6]), 64'(0));
        chk_mac("skew", exp_s);

        // Empty job: CLEAR then DONE, no beats requested.
        run_job("k0", 0, a_m, b_i, 99, 0, 2, -1);
        chk_mac("k0", exp_z);

        // Reset while the second of three beats is being accepted.
        start = 1'b1; k_len = 7'd3;
        tick();
        start = 1'b0;
        tick();
        vec_valid = 1'b1; a_vec = a_m[0]; b_vec = b_i[0];
        tick();
        a_vec = a_m[1]; b_vec = b_i[1];
        #1;
        rst = 1'b1;
        tick();
        chk("rstmid_busy", 64'(busy), 64'(0));
        chk("rstmid_act", 64'(act_out), 64'(0));
        chk("rstmid_wei", 64'(wei_out), 64'(0));
        chk("rstmid_pe", 64'(pipeline_en), 64'(0));
        chk("rstmid_rdy", 64'(vec_ready), 64'(0));
        rst = 1'b0; vec_valid = 1'b0; a_vec = '0; b_vec = '0;
        tick();

        // Abort in DRAIN, then a clean job with B = 2I.
        run_job("abrt", 3, a_m, b_i, 99, 0, 11, 6);
        run_job("post", 3, a_m, b_2i, 99, 0, 11, -1);
        chk_mac("post", exp_2a);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/os_sa_sequencer.md
Name: os_sa_sequencer

Overview:
Sequences one output-stationary matrix multiply, C = A x B, on the systolic_array.
- Accepts K column/row vector pairs over a valid/ready stream.
- Applies the diagonal input skew: lane i is delayed i cycles.
- Drives reg_clear and pipeline_en, drains the array and pulses done.
Sits between the operand buffers/DMA and the systolic_array act/wei/reg_clear/pipeline_en inputs. Results are read from MAC_out while the sequencer is idle.

Parameters:
WIDTH_A, 16, activation element width
WIDTH_B, 16, weight element width
X_AXIS, 3, array columns (weight lanes)
Y_AXIS, 3, array rows (activation lanes)
K_MAX, 64, maximum reduction length
PE_LAT, 1, PE accumulate latency in cycles (INTERMEDIATE_PIPELINE_STAGE+1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  begin a job; sampled only in IDLE
k_len  in  $clog2(K_MAX+1)  reduction length, latched on start
abort  in  1  return to IDLE, flush skew registers
vec_valid  in  1  a_vec/b_vec beat valid
vec_ready  out  1  beat accepted when vec_valid & vec_ready
a_vec  in  WIDTH_A*Y_AXIS  A[:,k]; lane i = bits [i*WIDTH_A +: WIDTH_A]
b_vec  in  WIDTH_B*X_AXIS  B[k,:]; lane j likewise
act_out  out  WIDTH_A*Y_AXIS  skewed activations to array act[]
wei_out  out  WIDTH_B*X_AXIS  skewed weights to array wei[]
reg_clear  out  1  array accumulator clear
pipeline_en  out  1  array advance enable
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse: MAC_out valid and stable

Behaviour:
- Reset (async, any state): state=IDLE; all skew registers, act_out, wei_out = 0; reg_clear=0; pipeline_en=0; vec_ready=0; busy=0; done=0.
- States: IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE:
  - pipeline_en=0, so array results hold.
  - start=1 latches k_len; next state is CLEAR.
- CLEAR: one cycle; reg_clear=1, pipeline_en=1, skew lanes forced to 0. Next state is FEED, or DONE if k_len==0 (all results zero).
- FEED:
  - vec_ready=1 until k_len beats are accepted; a beat counter counts accepted beats.
  - On an accepted beat: pipeline_en=1 and all skew registers shift.
  - On a cycle with no beat: pipeline_en=0 and all skew registers hold. The array and skew stall together, so bubbles are invisible to the math.
  - After the k_len-th beat, next state is DRAIN.
- Skew:
  - Lane i of act_out/wei_out passes through i+1 register stages; all stages advance only when pipeline_en=1.
  - An element accepted at cycle t appears on lane 0 at t+1 and on lane i at t+1+i (absent stalls).
- DRAIN:
  - Lasts X_AXIS+Y_AXIS-1+PE_LAT cycles, counted by a drain counter.
  - Zeros are shifted in; pipeline_en=1; vec_ready=0.
- DONE: one cycle; done=1, pipeline_en=0; next state is IDLE.
- abort (any non-IDLE state) has priority over all transitions:
  - Next state is IDLE; skew registers are zeroed; done is not pulsed; array contents are undefined.
- start outside IDLE is ignored. start together with abort in IDLE: abort wins and there is no job.
- k_len greater than K_MAX is saturated to K_MAX.
- Data are not modified; widths pass through unchanged.

Test Plan:
- Reset mid-FEED (rst at beat 2 of 3) -> next cycle busy=0, act_out=wei_out=0, pipeline_en=0, vec_ready=0.
- start at cycle 0, k_len=3, vec_valid continuous, A=[1 2 3;4 5 6;7 8 9], B=I3 (3x3, PE_LAT=1):
  - reg_clear=1 at cycle 1; beats accepted at cycles 2-4; DRAIN at cycles 5-10; done at cycle 11.
  - Array MAC_out equals A.
- Same job, vec_valid low at cycle 3 for 2 cycles -> pipeline_en=0 for those 2 cycles; act_out/wei_out frozen; done at cycle 13; results unchanged.
- Skew check, single beat a_vec={7,4,1}, b_vec={3,2,9}:
  - act lane0=1 at cycle t+1, lane1=4 at t+2, lane2=7 at t+3.
  - wei lanes follow the same pattern; all other cycles are 0.
- k_len=0 -> CLEAR then DONE: done two cycles after start, vec_ready never asserted, MAC_out all 0.
- abort during DRAIN -> IDLE next cycle, no done pulse; start in the following cycle runs a clean job with correct results.
